keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x6 matrix keypad scanner with per-key debounce and a
// press/release event FIFO.
// Optional feature macro: KEYSCAN_RELEASE_EV_EN -- when defined, release events
// are queued alongside press events; when undefined only presses are queued.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  keycol,
    output logic [3:0]  keyrow,
    output logic [23:0] button,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [4:0]  ev_code,
    output logic        ev_press,
    output logic        ev_ovf,
    input  logic        ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Row drive states, in scan order 0 -> 1 -> 2 -> 3 -> 0.
    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b0111;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b1101;

    // Board numbering of the six columns of a driven row, col 0 in the low field.
    function automatic logic [4:0] key_idx(input logic [3:0] row, input logic [2:0] col);
        logic [29:0] lut;
        case (row)
            ROW1:    lut = {5'd16, 5'd20, 5'd12, 5'd11, 5'd0,  5'd10};
            ROW2:    lut = {5'd17, 5'd21, 5'd13, 5'd9,  5'd8,  5'd7};
            ROW3:    lut = {5'd18, 5'd22, 5'd14, 5'd6,  5'd5,  5'd4};
            default: lut = {5'd19, 5'd23, 5'd15, 5'd3,  5'd2,  5'd1};
        endcase
        return lut[int'(col) * 5 +: 5];
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] row);
        case (row)
            ROW0:    return ROW1;
            ROW1:    return ROW2;
            ROW2:    return ROW3;
            default: return ROW0;
        endcase
    endfunction

    logic [3:0]  row_q, row_d;
    logic [15:0] div_q, div_d;
    logic        samp_take;
    logic        samp_vld_q;
    logic [3:0]  samp_row_q;
    logic [5:0]  samp_col_q;

    logic [23:0] btn_q, btn_d;
    logic [2:0]  agr_q [24];
    logic [2:0]  agr_d [24];
    logic [23:0] pend_q, pend_d, pend_set, pend_clr;
`ifdef KEYSCAN_RELEASE_EV_EN
    logic [23:0] pol_q, pol_d;
`endif

    logic        push;
    logic [4:0]  sel;
    logic        push_press;

    logic [5:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        full, pop, wr_en, drop;
    logic [5:0]  head;

    // Row sequencer: dwell SCAN_DIV cycles per row, request a sample on the
    // final dwell cycle, and snap any corrupted row value back to ROW0.
    always_comb begin
        row_d     = row_q;
        div_d     = div_q + 16'd1;
        samp_take = 1'b0;
        case (row_q)
            ROW0, ROW1, ROW2, ROW3: begin
                if (div_q == 16'(SCAN_DIV - 1)) begin
                    div_d     = 16'd0;
                    row_d     = next_row(row_q);
                    samp_take = 1'b1;
                end
            end
            default: begin
                row_d = ROW0;
                div_d = 16'd0;
            end
        endcase
    end

    // Debounce: compare the registered row sample against the accepted state;
    // DEBOUNCE consecutive disagreements flip the key and raise its event.
    always_comb begin
        logic [4:0] k;
        logic       hit;
        logic [2:0] inc;
        k        = '0;
        hit      = 1'b0;
        inc      = '0;
        btn_d    = btn_q;
        pend_set = '0;
        for (int i = 0; i < 24; i++) agr_d[i] = agr_q[i];
`ifdef KEYSCAN_RELEASE_EV_EN
        pol_d = pol_q;
`endif
        if (samp_vld_q) begin
            for (int c = 0; c < 6; c++) begin
                k   = key_idx(samp_row_q, 3'(c));
                hit = ~samp_col_q[c];
                inc = (agr_q[k] == 3'd7) ? 3'd7 : agr_q[k] + 3'd1;
                if (hit == btn_q[k]) begin
                    agr_d[k] = 3'd0;
                end else if (inc == 3'(DEBOUNCE)) begin
                    agr_d[k] = 3'd0;
                    btn_d[k] = hit;
`ifdef KEYSCAN_RELEASE_EV_EN
                    pend_set[k] = 1'b1;
                    pol_d[k]    = hit;
`else
                    pend_set[k] = hit;
`endif
                end else begin
                    agr_d[k] = inc;
                end
            end
        end
    end

    // Serialiser: lowest pending key goes to the FIFO this cycle. One row
    // raises at most six events, all drained well inside the 8+ cycle dwell.
    always_comb begin
        push = 1'b0;
        sel  = '0;
        for (int i = 23; i >= 0; i--) begin
            if (pend_q[i]) begin
                push = 1'b1;
                sel  = 5'(i);
            end
        end
        pend_clr = push ? (24'd1 << sel) : 24'd0;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
`ifdef KEYSCAN_RELEASE_EV_EN
        push_press = pol_q[sel];
`else
        push_press = 1'b1;
`endif
    end

    // FIFO control: a pop frees the slot for a same-cycle push even when full;
    // only a push into a full FIFO without a pop is dropped and flagged.
    always_comb begin
        full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
        pop   = ev_valid & ev_ready;
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (ovf_clr)   ovf_d = 1'b0;
        else if (drop) ovf_d = 1'b1;
        else           ovf_d = ovf_q;
    end

    // Control state with asynchronous reset; clears all in-flight events.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            row_q      <= ROW0;
            div_q      <= '0;
            samp_vld_q <= 1'b0;
            btn_q      <= '0;
            pend_q     <= '0;
            for (int i = 0; i < 24; i++) agr_q[i] <= '0;
`ifdef KEYSCAN_RELEASE_EV_EN
            pol_q      <= '0;
`endif
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            row_q      <= row_d;
            div_q      <= div_d;
            samp_vld_q <= samp_take;
            btn_q      <= btn_d;
            pend_q     <= pend_d;
            for (int i = 0; i < 24; i++) agr_q[i] <= agr_d[i];
`ifdef KEYSCAN_RELEASE_EV_EN
            pol_q      <= pol_d;
`endif
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Data capture: column sample with its row, and FIFO storage (no reset;
    // validity is carried by the control state above).
    always_ff @(posedge Clk) begin
        if (samp_take) begin
            samp_row_q <= row_q;
            samp_col_q <= keycol;
        end
        if (wr_en) mem_q[wr_q] <= {push_press, sel};
    end

    assign head     = mem_q[rd_q];
    assign keyrow   = row_q;
    assign button   = btn_q;
    assign ev_valid = (cnt_q != '0);
    assign ev_code  = ev_valid ? head[4:0] : 5'd0;
    assign ev_press = ev_valid & head[5];
    assign ev_ovf   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_DIV=8, DEBOUNCE=2, FIFO_DEPTH=4).
// Builds for either setting of KEYSCAN_RELEASE_EV_EN.
module tb_keypad_scan_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  keycol;
    logic [3:0]  keyrow;
    logic [23:0] button;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [4:0]  ev_code;
    logic        ev_press;
    logic        ev_ovf;
    logic        ovf_clr = 1'b0;

    logic [23:0] pressed = '0;
    int          errors = 0;
    int          checks = 0;
    logic [5:0]  exp_q [$];
    logic [5:0]  mon_exp;

    keypad_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .keycol(keycol), .keyrow(keyrow),
        .button(button), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_press(ev_press), .ev_ovf(ev_ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 Clk = ~Clk;

    // Board key at (row, col) per the keypad wiring table; -1 when no row driven.
    function automatic int tb_key(input logic [3:0] row, input int col);
        int t [6];
        case (row)
            4'b1110: t = '{1, 2, 3, 15, 23, 19};
            4'b1101: t = '{4, 5, 6, 14, 22, 18};
            4'b1011: t = '{7, 8, 9, 13, 21, 17};
            4'b0111: t = '{10, 0, 11, 12, 20, 16};
            default: return -1;
        endcase
        return t[col];
    endfunction

    // Switch matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        int k;
        k = 0;
        keycol = 6'h3F;
        for (int c = 0; c < 6; c++) begin
            k = tb_key(keyrow, c);
            if (k >= 0 && pressed[k]) keycol[c] = 1'b0;
        end
    end

    // Event monitor: every accepted head event is compared with the scoreboard.
    always @(negedge Clk) begin
        if (!Reset && ev_valid && ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ev_unexpected: got code=%0d press=%0d, required no event", ev_code, ev_press);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ev_press, ev_code} !== mon_exp) begin
                    errors++;
                    $display("FAIL ev_order: got code=%0d press=%0d, required code=%0d press=%0d",
                             ev_code, ev_press, mon_exp[4:0], mon_exp[5]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Advance to the negedge where keyrow has just switched to target.
    task automatic wait_row_enter(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        prev = keyrow;
        ok   = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge Clk);
            if (keyrow == target && prev != target) ok = 1'b1;
            prev = keyrow;
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge Clk);
        #1 ev_ready = v;
    endtask

    task automatic test_reset;
        logic [3:0] seq [4];
        seq = '{4'b1110, 4'b0111, 4'b1011, 4'b1101};
        Reset   = 1'b1;
        pressed = '0;
        cycles(3);
        checks++; if (keyrow !== 4'b1110) begin errors++; $display("FAIL rst_keyrow: got %b, required 1110", keyrow); end
        checks++; if (button !== 24'd0) begin errors++; $display("FAIL rst_button: got %h, required 0", button); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_ev_valid: got %b, required 0", ev_valid); end
        checks++; if (ev_code !== 5'd0 || ev_press !== 1'b0) begin errors++; $display("FAIL rst_ev_fields: got code=%0d press=%b, required 0/0", ev_code, ev_press); end
        checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, required 0", ev_ovf); end
        Reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            if (r > 0) cycles(8);
            checks++;
            if (keyrow !== seq[r % 4]) begin errors++; $display("FAIL row_seq[%0d]: got %b, required %b", r, keyrow, seq[r % 4]); end
        end
        checks++; if (ev_valid !== 1'b0 || button !== 24'd0) begin errors++; $display("FAIL idle_scan: got valid=%b button=%h, required 0/0", ev_valid, button); end
    endtask

    task automatic test_single_key;
        bit ok;
        wait_row_enter(4'b1011, ok);
        pressed[0] = 1'b1;
        exp_q.push_back({1'b1, 5'd0});
        wait_row_enter(4'b1011, ok);
        if (ok) wait_row_enter(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL key0_row_wait: got timeout, required row 1011"); end
        // negedge just after the accepting sample edge
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL lat_e0: got valid=%b, required 0", ev_valid); end
        cycles(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL lat_e1: got valid=%b, required 0", ev_valid); end
        cycles(1);
        checks++; if (ev_valid !== 1'b1 || ev_code !== 5'd0 || ev_press !== 1'b1) begin errors++; $display("FAIL lat_e2: got valid=%b code=%0d press=%b, required 1/0/1", ev_valid, ev_code, ev_press); end
        cycles(4);
        checks++; if (button !== 24'h000001) begin errors++; $display("FAIL key0_button: got %h, required 000001", button); end
        pressed[0] = 1'b0;
`ifdef KEYSCAN_RELEASE_EV_EN
        exp_q.push_back({1'b0, 5'd0});
`endif
        cycles(96);
        checks++; if (button !== 24'd0) begin errors++; $display("FAIL key0_release: got %h, required 0", button); end
        // one-frame glitch: exactly one sample of row 0111 sees the key
        wait_row_enter(4'b1011, ok);
        pressed[0] = 1'b1;
        cycles(32);
        pressed[0] = 1'b0;
        cycles(96);
        checks++; if (button !== 24'd0) begin errors++; $display("FAIL glitch_button: got %h, required 0", button); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL key0_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_row_burst;
        bit ok;
        int keys [6];
        logic [23:0] mask;
        keys = '{1, 2, 3, 15, 19, 23};
        mask = '0;
        wait_row_enter(4'b0111, ok);
        for (int i = 0; i < 6; i++) begin
            mask[keys[i]] = 1'b1;
            exp_q.push_back({1'b1, 5'(keys[i])});
        end
        pressed = mask;
        wait_row_enter(4'b0111, ok);
        if (ok) wait_row_enter(4'b0111, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_row_wait: got timeout, required row 0111"); end
        cycles(8);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_drain: got %0d undelivered at next sample, required 0", exp_q.size()); end
        checks++; if (button !== mask) begin errors++; $display("FAIL burst_button: got %h, required %h", button, mask); end
        pressed = '0;
`ifdef KEYSCAN_RELEASE_EV_EN
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 5'(keys[i])});
`endif
        cycles(96);
        checks++; if (button !== 24'd0 || exp_q.size() != 0) begin errors++; $display("FAIL burst_release: got button=%h pending=%0d, required 0/0", button, exp_q.size()); end
    endtask

    task automatic test_overflow;
        int keys [5];
        logic [23:0] mask;
        keys = '{4, 5, 6, 14, 22};
        mask = '0;
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) mask[keys[i]] = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 5'(keys[i])});
        pressed = mask;
        cycles(96);
        checks++; if (button !== mask) begin errors++; $display("FAIL ovf_button: got %h, required %h", button, mask); end
        checks++; if (ev_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", ev_ovf); end
        checks++; if (ev_valid !== 1'b1 || ev_code !== 5'd4 || ev_press !== 1'b1) begin errors++; $display("FAIL ovf_head: got valid=%b code=%0d press=%b, required 1/4/1", ev_valid, ev_code, ev_press); end
        cycles(5);
        checks++; if (ev_code !== 5'd4 || ev_press !== 1'b1) begin errors++; $display("FAIL ovf_hold: got code=%0d press=%b, required 4/1", ev_code, ev_press); end
        @(posedge Clk);
        #1 ovf_clr = 1'b1;
        @(posedge Clk);
        #1 ovf_clr = 1'b0;
        checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", ev_ovf); end
        set_ready(1'b1);
        cycles(10);
        checks++; if (exp_q.size() != 0 || ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got pending=%0d valid=%b, required 0/0", exp_q.size(), ev_valid); end
        pressed = '0;
`ifdef KEYSCAN_RELEASE_EV_EN
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 5'(keys[i])});
`endif
        cycles(96);
        checks++; if (button !== 24'd0 || ev_ovf !== 1'b0) begin errors++; $display("FAIL ovf_release: got button=%h ovf=%b, required 0/0", button, ev_ovf); end
    endtask

    task automatic test_release_key9;
        exp_q.push_back({1'b1, 5'd9});
        pressed[9] = 1'b1;
        cycles(96);
        checks++; if (button !== 24'h000200) begin errors++; $display("FAIL key9_press: got %h, required 000200", button); end
        pressed[9] = 1'b0;
`ifdef KEYSCAN_RELEASE_EV_EN
        exp_q.push_back({1'b0, 5'd9});
`endif
        cycles(96);
        checks++; if (button !== 24'd0 || exp_q.size() != 0) begin errors++; $display("FAIL key9_release: got button=%h pending=%0d, required 0/0", button, exp_q.size()); end
    endtask

    task automatic test_async_reset;
        bit ok;
        set_ready(1'b0);
        pressed[7] = 1'b1;
        pressed[8] = 1'b1;
        cycles(96);
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL ar_queued: got valid=%b, required 1", ev_valid); end
        wait_row_enter(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ar_row_wait: got timeout, required row 1011"); end
        #2 Reset = 1'b1;
        #1;
        checks++; if (keyrow !== 4'b1110) begin errors++; $display("FAIL ar_keyrow: got %b, required 1110", keyrow); end
        checks++; if (ev_valid !== 1'b0 || button !== 24'd0) begin errors++; $display("FAIL ar_clear: got valid=%b button=%h, required 0/0", ev_valid, button); end
        pressed = '0;
        @(negedge Clk);
        Reset    = 1'b0;
        ev_ready = 1'b1;
        cycles(7);
        checks++; if (keyrow !== 4'b1110) begin errors++; $display("FAIL ar_dwell: got %b, required 1110", keyrow); end
        cycles(1);
        checks++; if (keyrow !== 4'b0111) begin errors++; $display("FAIL ar_next_row: got %b, required 0111", keyrow); end
        cycles(96);
        checks++; if (exp_q.size() != 0 || ev_valid !== 1'b0) begin errors++; $display("FAIL ar_quiet: got pending=%0d valid=%b, required 0/0", exp_q.size(), ev_valid); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_row_burst();
        test_overflow();
        test_release_key9();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before 500000");
        $fatal(1);
    end

endmodule
